// File: rtl/trace_stimulus_player.sv
// Replays a stored trace of timed events onto monitor input/new_input pairs as one-cycle pulses.
// Optional macro TRACE_PLAYER_LOOP_EN adds a 'loop' input for continuous replay of the trace.
module trace_stimulus_player #(
    parameter int NUM_INPUTS  = 2,
    parameter int DATA_WIDTH  = 64,
    parameter int DEPTH       = 16,
    parameter int DELTA_WIDTH = 16,
    parameter int ADDR_WIDTH  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DELTA_WIDTH-1:0]           wr_delta,
    input  logic [NUM_INPUTS-1:0]            wr_mask,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] wr_values,
    input  logic [ADDR_WIDTH:0]              num_entries,
`ifdef TRACE_PLAYER_LOOP_EN
    input  logic                             loop,
`endif
    input  logic                             start,
    input  logic                             abort,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] input_values,
    output logic [NUM_INPUTS-1:0]            new_inputs,
    output logic                             busy,
    output logic                             done,
    output logic [ADDR_WIDTH:0]              event_count,
    output logic                             wr_drop
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FIRE  = 2'd2;
    localparam logic [1:0] S_CLEAR = 2'd3;

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_MAX = '1;

    logic [DELTA_WIDTH-1:0]           r_mem_delta  [DEPTH];
    logic [NUM_INPUTS-1:0]            r_mem_mask   [DEPTH];
    logic [NUM_INPUTS*DATA_WIDTH-1:0] r_mem_values [DEPTH];

    logic [1:0]                       r_state;
    logic [ADDR_WIDTH-1:0]            r_idx;
    logic [ADDR_WIDTH:0]              r_len;
    logic [DELTA_WIDTH-1:0]           r_cnt;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] r_values;
    logic [NUM_INPUTS-1:0]            r_new;
    logic                             r_busy;
    logic                             r_done;
    logic [ADDR_WIDTH:0]              r_event_count;
    logic                             r_wr_drop;

    logic                             w_wr_ok;
    logic                             w_last;
    logic [ADDR_WIDTH-1:0]            w_next_idx;
    logic [ADDR_WIDTH-1:0]            w_rd_addr;
    logic                             w_fwd;
    logic [DELTA_WIDTH-1:0]           w_rd_delta;
    logic [NUM_INPUTS-1:0]            w_rd_mask;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] w_rd_values;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] w_fire_values;
    logic [ADDR_WIDTH:0]              w_len_clamped;
    logic [ADDR_WIDTH:0]              w_count_inc;
    logic                             w_loop;

`ifdef TRACE_PLAYER_LOOP_EN
    logic r_loop;
    assign w_loop = r_loop;

    always_ff @(posedge clk) begin
        if (rst)
            r_loop <= 1'b0;
        else if (en && r_state == S_IDLE && start && !abort)
            r_loop <= loop;
    end
`else
    assign w_loop = 1'b0;
`endif

    assign w_wr_ok       = wr_en && (r_state == S_IDLE) && ({1'b0, wr_addr} < DEPTH_L);
    assign w_last        = ({1'b0, r_idx} + (ADDR_WIDTH+1)'(1)) == r_len;
    assign w_next_idx    = w_last ? '0 : r_idx + ADDR_WIDTH'(1);
    assign w_len_clamped = (num_entries > DEPTH_L) ? DEPTH_L : num_entries;
    assign w_count_inc   = (w_loop || r_event_count != CNT_MAX) ? r_event_count + (ADDR_WIDTH+1)'(1)
                                                                : r_event_count;

    // The entry about to be scheduled is read combinationally, with a bypass for a same-cycle
    // write, so a zero-delay entry can fire on the very next cycle.
    always_comb begin
        w_rd_addr = r_idx;
        if (r_state == S_IDLE)
            w_rd_addr = '0;
        else if (r_state == S_CLEAR)
            w_rd_addr = w_next_idx;
        w_fwd       = w_wr_ok && (wr_addr == w_rd_addr);
        w_rd_delta  = w_fwd ? wr_delta  : r_mem_delta[w_rd_addr];
        w_rd_mask   = w_fwd ? wr_mask   : r_mem_mask[w_rd_addr];
        w_rd_values = w_fwd ? wr_values : r_mem_values[w_rd_addr];
        w_fire_values = '0;
        for (int i = 0; i < NUM_INPUTS; i++)
            if (w_rd_mask[i])
                w_fire_values[i*DATA_WIDTH +: DATA_WIDTH] = w_rd_values[i*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst && en && w_wr_ok) begin
            r_mem_delta[wr_addr]  <= wr_delta;
            r_mem_mask[wr_addr]   <= wr_mask;
            r_mem_values[wr_addr] <= wr_values;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_values      <= '0;
            r_new         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_event_count <= '0;
            r_wr_drop     <= 1'b0;
        end else if (en) begin
            r_done    <= 1'b0;
            r_wr_drop <= wr_en && !w_wr_ok;
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_event_count <= '0;
                        r_len         <= w_len_clamped;
                        r_idx         <= '0;
                        if (w_len_clamped == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_busy <= 1'b1;
                            if (w_rd_delta == '0) begin
                                r_state       <= S_FIRE;
                                r_new         <= w_rd_mask;
                                r_values      <= w_fire_values;
                                r_event_count <= (ADDR_WIDTH+1)'(1);
                            end else begin
                                r_state <= S_WAIT;
                                r_cnt   <= w_rd_delta - DELTA_WIDTH'(1);
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state       <= S_FIRE;
                        r_new         <= w_rd_mask;
                        r_values      <= w_fire_values;
                        r_event_count <= w_count_inc;
                    end else begin
                        r_cnt <= r_cnt - DELTA_WIDTH'(1);
                    end
                end
                S_FIRE: begin
                    r_new    <= '0;
                    r_values <= '0;
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_CLEAR;
                        r_done  <= w_last;
                    end
                end
                default: begin
                    if (abort || (w_last && !w_loop)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_idx <= w_next_idx;
                        if (w_rd_delta == '0) begin
                            r_state       <= S_FIRE;
                            r_new         <= w_rd_mask;
                            r_values      <= w_fire_values;
                            r_event_count <= w_count_inc;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= w_rd_delta - DELTA_WIDTH'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign input_values = r_values;
    assign new_inputs   = r_new;
    assign busy         = r_busy;
    assign done         = r_done;
    assign event_count  = r_event_count;
    assign wr_drop      = r_wr_drop;

endmodule
